// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone classic slave backed by byte-lane memory.
//
// Each accepted request passes IDLE -> WAIT (cfg_wait extra cycles) -> TERM.
// TERM drives a one-cycle registered ack or err and doubles as the bus
// turnaround cycle. Error termination is chosen for out-of-range addresses
// or for a match against the injection address. Statistics counters
// saturate at 0xFFFF.
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   adr, dat_w, sel      byte address, write data, byte-lane enables
//   cyc, stb, we         Wishbone cycle, strobe, write enable
//   cti, bte             cycle-type tags (cti feeds burst_beats only)
//   dat_r, ack, err      registered read data and terminations
//   cfg_wait             wait states before termination
//   cfg_err_en/adr       error injection at a matching address
//   wr_count, rd_count   acked writes / reads
//   burst_beats          acked beats tagged as burst (cti 001 or 010)

// One byte lane of storage. The read is combinational so the top can
// register the full word on the edge entering TERM.
module wb_mem_lane #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          wen,
   input  logic [AW-1:0] idx,
   input  logic [7:0]    byte_w,
   output logic [7:0]    byte_r
);
   logic [7:0] store [2**AW];

   always_ff @(posedge clk)
      if (wen) store[idx] <= byte_w;

   assign byte_r = store[idx];
endmodule

module wb_slave_mem #(
   parameter int WB_ADDR_WIDTH = 32,
   parameter int WB_DATA_WIDTH = 32,
   parameter int MEM_WORDS     = 1024
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [WB_ADDR_WIDTH-1:0]   adr,
   input  logic [WB_DATA_WIDTH-1:0]   dat_w,
   output logic [WB_DATA_WIDTH-1:0]   dat_r,
   input  logic [WB_DATA_WIDTH/8-1:0] sel,
   input  logic                       cyc,
   input  logic                       stb,
   input  logic                       we,
   input  logic [2:0]                 cti,
   input  logic [1:0]                 bte,
   output logic                       ack,
   output logic                       err,
   input  logic [3:0]                 cfg_wait,
   input  logic                       cfg_err_en,
   input  logic [WB_ADDR_WIDTH-1:0]   cfg_err_adr,
   output logic [15:0]                wr_count,
   output logic [15:0]                rd_count,
   output logic [15:0]                burst_beats
);
   localparam int LANES = WB_DATA_WIDTH / 8;
   localparam int BW    = $clog2(LANES);
   localparam int AW    = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;

   state_t                   state;
   logic [3:0]               wcnt;
   logic [AW-1:0]            idx_q;
   logic                     we_q;
   logic [LANES-1:0]         sel_q;
   logic [WB_DATA_WIDTH-1:0] dat_q;
   logic [2:0]               cti_q;
   logic                     err_q;

   logic                     oor;
   logic                     acc_err;
   logic                     go_term;
   logic [LANES-1:0][7:0]    rd_bytes;
   logic [WB_DATA_WIDTH-1:0] rd_word;

   // bte carries no meaning for this slave: every beat is a single access.
   logic unused_bte;
   assign unused_bte = ^bte;

   // Any address bit above the word-index field puts the access out of range.
   assign oor     = |(adr >> (BW + AW));
   // The error decision is taken at acceptance so that later changes to the
   // injection controls cannot affect a transfer already in flight.
   assign acc_err = oor | (cfg_err_en & (adr == cfg_err_adr));
   assign go_term = (state == WAIT) && cyc && (wcnt == 4'd0);
   assign rd_word = rd_bytes;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      wb_mem_lane #(.AW(AW)) u_lane (
         .clk    (clk),
         // Gating with rstn keeps a transfer cut by reset from committing.
         .wen    (rstn & go_term & ~err_q & we_q & sel_q[i]),
         .idx    (idx_q),
         .byte_w (dat_q[8*i +: 8]),
         .byte_r (rd_bytes[i])
      );
   end

   function automatic logic [15:0] bump(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         ack         <= 1'b0;
         err         <= 1'b0;
         dat_r       <= '0;
         wcnt        <= '0;
         wr_count    <= '0;
         rd_count    <= '0;
         burst_beats <= '0;
      end else begin
         case (state)
            IDLE: begin
               ack   <= 1'b0;
               err   <= 1'b0;
               dat_r <= '0;
               if (cyc && stb) begin
                  state <= WAIT;
                  wcnt  <= cfg_wait;
                  idx_q <= adr[BW +: AW];
                  we_q  <= we;
                  sel_q <= sel;
                  dat_q <= dat_w;
                  cti_q <= cti;
                  err_q <= acc_err;
               end
            end
            WAIT: begin
               if (!cyc) begin
                  // Master abandoned the cycle: no termination, no write.
                  state <= IDLE;
               end else if (wcnt == 4'd0) begin
                  state <= TERM;
                  if (err_q) begin
                     err <= 1'b1;
                  end else begin
                     ack   <= 1'b1;
                     dat_r <= we_q ? '0 : rd_word;
                     if (we_q) wr_count <= bump(wr_count);
                     else      rd_count <= bump(rd_count);
                     if (cti_q == 3'b001 || cti_q == 3'b010)
                        burst_beats <= bump(burst_beats);
                  end
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end
            TERM: begin
               // Turnaround: a strobe still high here is deliberately ignored.
               ack   <= 1'b0;
               err   <= 1'b0;
               dat_r <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
